// File: rtl/monitoreo_sched.sv
// Time-multiplexes N_CANAL sensor channels onto one monitoring datapath:
// round-robin grant, fixed dwell, one capture cycle, then a neutral flush.
module monitoreo_sched #(
  parameter int N_CANAL     = 4,
  parameter int TEMP_W      = 10,
  parameter int DWELL       = 8,
  parameter int FLUSH_CYC   = 2,
  parameter int TEMP_NEUTRA = 220
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [N_CANAL-1:0]          req,
  input  logic [N_CANAL*TEMP_W-1:0]   temp_canal,
  input  logic [N_CANAL-1:0]          clr_alerta,
  input  logic                        alerta_monitor,
  output logic [TEMP_W-1:0]           temp_entrada,
  output logic [N_CANAL-1:0]          gnt,
  output logic [1:0]                  canal_activo,
  output logic [N_CANAL-1:0]          alerta_canal,
  output logic [1:0]                  estado_sched
);

  // Handshake: req[i] high means channel i holds a valid sample; gnt is
  // one-hot while the channel owns the datapath and must stay requested for
  // the whole dwell, otherwise the grant is aborted without capture.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DWELL   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_FLUSH   = 2'b11
  } estado_t;

  localparam logic [7:0]        DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0]        FLUSH_LAST = 4'(FLUSH_CYC - 1);
  localparam logic [TEMP_W-1:0] NEUTRA     = TEMP_W'(TEMP_NEUTRA);
  localparam logic [1:0]        CANAL_LAST = 2'(N_CANAL - 1);
  localparam logic [2:0]        N_MOD      = 3'(N_CANAL);

  if (N_CANAL < 1 || N_CANAL > 4) begin : g_bad_n_canal
    $error("N_CANAL must be 1..4 to fit the 2-bit channel index");
  end
  if (DWELL < 7 || DWELL > 255) begin : g_bad_dwell
    $error("DWELL must be 7..255");
  end
  if (FLUSH_CYC < 1 || FLUSH_CYC > 15) begin : g_bad_flush
    $error("FLUSH_CYC must be 1..15");
  end

  estado_t              estado_q, estado_d;
  logic [1:0]           canal_q, canal_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [7:0]           dcnt_q, dcnt_d;
  logic [3:0]           fcnt_q, fcnt_d;
  logic [TEMP_W-1:0]    temp_q, temp_d;
  logic [N_CANAL-1:0]   alerta_q, alerta_d;

  logic [TEMP_W-1:0]    temp_arr [N_CANAL];
  logic                 hay_req;
  logic [1:0]           sel;
  logic [2:0]           cand;
  logic [1:0]           canal_sig;

  always_comb begin
    for (int i = 0; i < N_CANAL; i++) begin
      temp_arr[i] = temp_canal[i*TEMP_W +: TEMP_W];
    end
  end

  // Scan offsets from the highest down so the smallest offset from ptr wins.
  always_comb begin
    hay_req = 1'b0;
    sel     = ptr_q;
    cand    = '0;
    for (int i = N_CANAL - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + 3'(i);
      if (cand >= N_MOD) begin
        cand = cand - N_MOD;
      end
      if (req[cand[1:0]]) begin
        hay_req = 1'b1;
        sel     = cand[1:0];
      end
    end
  end

  assign canal_sig = (canal_q == CANAL_LAST) ? 2'd0 : canal_q + 2'd1;

  always_comb begin
    estado_d = estado_q;
    canal_d  = canal_q;
    ptr_d    = ptr_q;
    dcnt_d   = dcnt_q;
    fcnt_d   = fcnt_q;
    alerta_d = alerta_q & ~clr_alerta;
    case (estado_q)
      ST_IDLE: begin
        if (hay_req) begin
          estado_d = ST_DWELL;
          canal_d  = sel;
          dcnt_d   = '0;
        end
      end
      ST_DWELL: begin
        if (!req[canal_q]) begin
          estado_d = ST_FLUSH;
          ptr_d    = canal_sig;
          dcnt_d   = '0;
          fcnt_d   = '0;
        end else if (dcnt_q == DWELL_LAST) begin
          estado_d = ST_CAPTURE;
          ptr_d    = canal_sig;
          dcnt_d   = '0;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      ST_CAPTURE: begin
        estado_d = ST_FLUSH;
        ptr_d    = canal_sig;
        fcnt_d   = '0;
        // Applied after the clear so a coincident capture set wins.
        if (alerta_monitor) begin
          alerta_d[canal_q] = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == FLUSH_LAST) begin
          estado_d = ST_IDLE;
          fcnt_d   = '0;
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      default: estado_d = ST_IDLE;
    endcase

    // Keyed on the next state so the first dwell cycle already shows the
    // channel and the first flush cycle already shows the neutral value.
    if (estado_d == ST_DWELL || estado_d == ST_CAPTURE) begin
      temp_d = temp_arr[canal_d];
    end else begin
      temp_d = NEUTRA;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      estado_q <= ST_IDLE;
      canal_q  <= '0;
      ptr_q    <= '0;
      dcnt_q   <= '0;
      fcnt_q   <= '0;
      temp_q   <= NEUTRA;
      alerta_q <= '0;
    end else begin
      estado_q <= estado_d;
      canal_q  <= canal_d;
      ptr_q    <= ptr_d;
      dcnt_q   <= dcnt_d;
      fcnt_q   <= fcnt_d;
      temp_q   <= temp_d;
      alerta_q <= alerta_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (estado_q == ST_DWELL || estado_q == ST_CAPTURE) begin
      gnt[canal_q] = 1'b1;
    end
  end

  assign temp_entrada = temp_q;
  assign canal_activo = canal_q;
  assign alerta_canal = alerta_q;
  assign estado_sched = estado_q;

endmodule

// File: tb/tb_monitoreo_sched.sv
// Directed bench for monitoreo_sched: reset, single grant, sticky alert,
// round-robin spacing, abort, clear/set priority and asynchronous reset.
module tb_monitoreo_sched;

  localparam int N  = 4;
  localparam int TW = 10;

  logic            clk = 1'b0;
  logic            arst_n;
  logic [N-1:0]    req;
  logic [N*TW-1:0] temp_canal;
  logic [N-1:0]    clr_alerta;
  logic            alerta_monitor;
  logic [TW-1:0]   temp_entrada;
  logic [N-1:0]    gnt;
  logic [1:0]      canal_activo;
  logic [N-1:0]    alerta_canal;
  logic [1:0]      estado_sched;

  int n_checks = 0;
  int n_errors = 0;

  monitoreo_sched dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .req            (req),
    .temp_canal     (temp_canal),
    .clr_alerta     (clr_alerta),
    .alerta_monitor (alerta_monitor),
    .temp_entrada   (temp_entrada),
    .gnt            (gnt),
    .canal_activo   (canal_activo),
    .alerta_canal   (alerta_canal),
    .estado_sched   (estado_sched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_temp(input int ch, input logic [TW-1:0] val);
    temp_canal[ch*TW +: TW] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] exp_t [N];
    logic [N-1:0]  exp_g;
    int            ch;

    arst_n         = 1'b0;
    req            = '0;
    clr_alerta     = '0;
    alerta_monitor = 1'b0;
    for (int i = 0; i < N; i++) set_temp(i, 10'd220);

    // Reset values
    tick(2);
    check("rst_estado", estado_sched, 2'b00);
    check("rst_gnt",    gnt,          4'b0000);
    check("rst_temp",   temp_entrada, 220);
    check("rst_canal",  canal_activo, 0);
    check("rst_alerta", alerta_canal, 4'b0000);
    arst_n = 1'b1;

    // Single request on ch2: 8 dwell + 1 capture cycles of grant
    req = 4'b0100;
    for (int c = 1; c <= 9; c++) begin
      tick(1);
      check("single_gnt",    gnt,          4'b0100);
      check("single_temp",   temp_entrada, 220);
      check("single_estado", estado_sched, (c <= 8) ? 2'b01 : 2'b10);
    end
    req = '0;
    for (int c = 1; c <= 2; c++) begin
      tick(1);
      check("single_flush_estado", estado_sched, 2'b11);
      check("single_flush_gnt",    gnt,          4'b0000);
    end
    tick(1);
    check("single_idle",   estado_sched, 2'b00);
    check("single_alerta", alerta_canal, 4'b0000);
    check("single_canal",  canal_activo, 2);

    // Persistent heat on ch1 (ptr is now 3, search wraps to ch1)
    set_temp(1, 10'd300);
    req = 4'b0010;
    for (int c = 1; c <= 9; c++) begin
      tick(1);
      if (c == 1) begin
        check("heat_gnt",   gnt,          4'b0010);
        check("heat_temp",  temp_entrada, 300);
        check("heat_canal", canal_activo, 1);
      end
      if (c == 6) alerta_monitor = 1'b1;
    end
    check("heat_capture_estado", estado_sched, 2'b10);
    check("heat_pre_alerta",     alerta_canal, 4'b0000);
    req = '0;
    tick(1);
    check("heat_alerta_set",  alerta_canal, 4'b0010);
    check("heat_flush_temp",  temp_entrada, 220);
    alerta_monitor = 1'b0;
    tick(3);
    check("heat_alerta_held", alerta_canal, 4'b0010);
    clr_alerta = 4'b0010;
    tick(1);
    check("heat_alerta_clr",  alerta_canal, 4'b0000);
    clr_alerta = '0;

    // Round-robin with all channels requesting from reset
    exp_t[0] = 10'd100; exp_t[1] = 10'd300; exp_t[2] = 10'd220; exp_t[3] = 10'd500;
    for (int i = 0; i < N; i++) set_temp(i, exp_t[i]);
    arst_n = 1'b0;
    req    = 4'b1111;
    tick(2);
    arst_n = 1'b1;
    for (int cyc = 1; cyc <= 49; cyc++) begin
      tick(1);
      if (cyc % 12 == 0) check("rr_gap_gnt", gnt, 4'b0000);
      if (cyc % 12 == 1) begin
        ch    = (cyc / 12) % N;
        exp_g = 4'b0001 << ch;
        check("rr_gnt",   gnt,          exp_g);
        check("rr_canal", canal_activo, ch);
        check("rr_temp",  temp_entrada, exp_t[ch]);
      end
    end

    // Abort: ch3 drops its request during dwell cycle 3
    arst_n = 1'b0;
    req    = 4'b1000;
    tick(2);
    arst_n         = 1'b1;
    alerta_monitor = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick(1);
      if (c == 1) begin
        check("abort_gnt",  gnt,          4'b1000);
        check("abort_temp", temp_entrada, 500);
      end
    end
    req = 4'b0011;
    tick(1);
    check("abort_flush_estado", estado_sched, 2'b11);
    check("abort_flush_gnt",    gnt,          4'b0000);
    check("abort_alerta",       alerta_canal, 4'b0000);
    tick(3);
    check("abort_next_gnt",   gnt,          4'b0001);
    check("abort_next_canal", canal_activo, 0);

    // Clear coinciding with a capture set on ch0: set wins
    tick(8);
    check("setwin_capture", estado_sched, 2'b10);
    clr_alerta = 4'b0001;
    tick(1);
    check("setwin_alerta", alerta_canal, 4'b0001);
    clr_alerta     = '0;
    alerta_monitor = 1'b0;
    req            = 4'b0001;

    // Asynchronous reset in dwell cycle 4 of the next ch0 grant
    tick(3);
    check("midrst_pre_gnt", gnt, 4'b0001);
    tick(3);
    check("midrst_pre_temp",   temp_entrada, 100);
    check("midrst_pre_alerta", alerta_canal, 4'b0001);
    arst_n = 1'b0;
    #1;
    check("midrst_gnt",    gnt,          4'b0000);
    check("midrst_alerta", alerta_canal, 4'b0000);
    check("midrst_temp",   temp_entrada, 220);
    check("midrst_estado", estado_sched, 2'b00);
    check("midrst_canal",  canal_activo, 0);
    tick(2);
    arst_n = 1'b1;
    req    = '0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/monitoreo_sched.md
MONITOREO_SCHED -- requirements
Module: monitoreo_sched

Interface
REQ-001 The block SHALL have one clock, clk; reset arst_n SHALL be asynchronous and active-low.
REQ-002 Parameter N_CANAL, default 4, SHALL set the number of sensor channels sharing one monitoring datapath.
REQ-003 Parameter TEMP_W, default 10, SHALL set the temperature width in tenths of a degree.
REQ-004 Parameter DWELL, default 8, SHALL set datapath cycles per grant; legal range 7..255.
REQ-005 Parameter FLUSH_CYC, default 2, SHALL set neutral cycles between grants; legal range 1..15.
REQ-006 Parameter TEMP_NEUTRA, default 220, SHALL set the temperature driven when no channel is granted.
REQ-007 Port clk, input, 1, SHALL be the system clock.
REQ-008 Port arst_n, input, 1, SHALL be the async active-low reset.
REQ-009 Port req, input, N_CANAL, SHALL mark channel i as holding a valid sample.
REQ-010 Port temp_canal, input, N_CANAL*TEMP_W, SHALL carry packed channel temperatures, channel i at bits [i*TEMP_W +: TEMP_W].
REQ-011 Port clr_alerta, input, N_CANAL, SHALL clear the sticky alert of channel i.
REQ-012 Port alerta_monitor, input, 1, SHALL be the datapath alert output.
REQ-013 Port temp_entrada, output, TEMP_W, SHALL be the registered temperature driven into the datapath.
REQ-014 Port gnt, output, N_CANAL, SHALL be a one-hot or zero grant.
REQ-015 Port canal_activo, output, 2, SHALL be the index of the granted or last-granted channel.
REQ-016 Port alerta_canal, output, N_CANAL, SHALL hold the sticky per-channel alert flags.
REQ-017 Port estado_sched, output, 2, SHALL encode the FSM state: IDLE=00, DWELL=01, CAPTURE=10, FLUSH=11.

Function
REQ-018 The FSM SHALL have the states IDLE, DWELL, CAPTURE and FLUSH.
REQ-019 In IDLE with any req bit high, the next edge SHALL grant the first requesting channel searching upward from pointer ptr modulo N_CANAL, load that channel into canal_activo, and enter DWELL.
REQ-020 In IDLE with req equal to zero, the FSM SHALL stay in IDLE with gnt equal to zero.
REQ-021 In DWELL, every edge SHALL load temp_entrada from the granted channel's temp_canal slice, and gnt SHALL be one-hot on canal_activo.
REQ-022 A dwell counter SHALL count 0..DWELL-1, and the edge at count DWELL-1 SHALL enter CAPTURE, so DWELL lasts exactly DWELL cycles.
REQ-023 If req[canal_activo] drops during DWELL, the next edge SHALL enter FLUSH without capture and alerta_canal SHALL stay unchanged.
REQ-024 CAPTURE SHALL last one cycle with gnt held, and its ending edge SHALL set alerta_canal[canal_activo] when alerta_monitor is 1.
REQ-025 On leaving DWELL or CAPTURE, ptr SHALL become (canal_activo+1) mod N_CANAL; on abort, ptr SHALL still advance.
REQ-026 FLUSH SHALL drive gnt to zero and temp_entrada to TEMP_NEUTRA for exactly FLUSH_CYC cycles, then enter IDLE.
REQ-027 In IDLE, temp_entrada SHALL equal TEMP_NEUTRA.
REQ-028 clr_alerta[i] SHALL clear alerta_canal[i] at the next edge; when a clear coincides with a CAPTURE set on the same bit, the set SHALL win.
REQ-029 A full grant cycle SHALL take 1 IDLE + DWELL + 1 CAPTURE + FLUSH_CYC cycles, which is 12 at the defaults.
REQ-030 All counters SHALL saturate-free wrap only through the FSM, and no counter SHALL exceed its parameter range.

Reset
REQ-031 While arst_n is 0, the block SHALL immediately force the following values, including mid-operation:
- estado_sched = IDLE
- gnt = 0
- temp_entrada = TEMP_NEUTRA
- canal_activo = 0
- alerta_canal = 0
- ptr = 0
- all counters = 0
REQ-032 After arst_n releases, the first arbitration SHALL occur on the first edge at which req is nonzero.

Verification
REQ-033 Reset: hold arst_n at 0 for 2 cycles -> outputs SHALL equal the REQ-031 values, with temp_entrada = 220.
REQ-034 Single request: req = 0100 with ch2 at 220 -> gnt = 0100 for 9 cycles, temp_entrada = 220 throughout, and alerta_canal stays 0000.
REQ-035 Persistent heat: req = 0010 with ch1 at 300 and alerta_monitor rising on DWELL cycle 6 -> alerta_canal = 0010 after CAPTURE, held until clr_alerta = 0010.
REQ-036 Round-robin: req = 1111 held continuously from reset -> grants SHALL follow the order 0, 1, 2, 3, 0, with 12-cycle spacing.
REQ-037 Abort: ch3 req drops on DWELL cycle 3 -> FLUSH next cycle, alerta_canal unchanged, and the next grant goes to ch0.
REQ-038 Reset mid-DWELL: arst_n to 0 on DWELL cycle 4 with alerta_canal = 0001 -> gnt = 0, alerta_canal = 0000 and temp_entrada = 220 immediately.
